// File: rtl/de10_input.sv
// Debounced DE10 switch/key reader exposed as an IOT register block, with
// sticky press/release/change flags and a maskable interrupt request.
module de10_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  sw_in,
  input  logic [1:0]  key_in,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic [11:0] wdata,
  output logic [11:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_SW    = 3'd0;
  localparam logic [2:0] A_KEY   = 3'd1;
  localparam logic [2:0] A_SWCHG = 3'd2;
  localparam logic [2:0] A_IEN   = 3'd3;
  localparam logic [2:0] A_CLR   = 3'd7;

  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [1:0]       key_s1_q, key_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // Bit layout of histories and debounced state: [11:10] keys (1 = pressed), [9:0] switches.
  logic [11:0] hist0_q, hist1_q, hist2_q;
  logic [11:0] hist0_d, hist1_d, hist2_d;
  logic [11:0] db_q, db_d;
  logic [11:0] in_sync;
  logic [11:0] all1, all0;

  logic [1:0] kpress_q, kpress_d, krel_q, krel_d;
  logic       swchg_q, swchg_d;
  logic [2:0] ien_q, ien_d;
  logic       irq_q, irq_d;

  logic       rd_en, wr_en;
  logic [1:0] kp_set, kr_set, kp_clr, kr_clr;
  logic       sc_set, sc_clr;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[11:5];

  // Sync stage: two flops per raw input; keys idle high (released) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= 10'd0;
      sw_s2_q  <= 10'd0;
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
    end else begin
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key_in;
      key_s2_q <= key_s1_q;
    end
  end

  assign in_sync = {~key_s2_q, sw_s2_q};

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Debounce: compare against the history as it will be after this tick's shift,
  // so the debounced state moves on the same edge the third agreeing sample lands.
  always_comb begin
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    db_d    = db_q;
    all1    = '0;
    all0    = '0;
    if (tick) begin
      hist0_d = in_sync;
      hist1_d = hist0_q;
      hist2_d = hist1_q;
      all1    = hist0_d & hist1_d & hist2_d;
      all0    = ~(hist0_d | hist1_d | hist2_d);
      db_d    = (db_q | all1) & ~all0;
    end
  end

  assign kp_set = db_d[11:10] & ~db_q[11:10];
  assign kr_set = ~db_d[11:10] & db_q[11:10];
  assign sc_set = |(db_d[9:0] ^ db_q[9:0]);

  assign rd_en = sel & ~we;
  assign wr_en = sel & we;

  assign kp_clr = {2{rd_en && (addr == A_KEY)}} | ({2{wr_en && (addr == A_CLR)}} & wdata[1:0]);
  assign kr_clr = {2{rd_en && (addr == A_KEY)}} | ({2{wr_en && (addr == A_CLR)}} & wdata[3:2]);
  assign sc_clr = (rd_en && (addr == A_SWCHG)) || (wr_en && (addr == A_CLR) && wdata[4]);

  // A set event on the same edge as a clear wins.
  always_comb begin
    kpress_d = (kpress_q & ~kp_clr) | kp_set;
    krel_d   = (krel_q & ~kr_clr) | kr_set;
    swchg_d  = (swchg_q & ~sc_clr) | sc_set;
    ien_d    = ien_q;
    if (wr_en && (addr == A_IEN)) begin
      ien_d = wdata[2:0];
    end
    irq_d = (|(kpress_q & {2{ien_q[0]}})) | (|(krel_q & {2{ien_q[1]}})) | (swchg_q & ien_q[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hist0_q  <= '0;
      hist1_q  <= '0;
      hist2_q  <= '0;
      db_q     <= '0;
      kpress_q <= '0;
      krel_q   <= '0;
      swchg_q  <= 1'b0;
      ien_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hist0_q  <= hist0_d;
      hist1_q  <= hist1_d;
      hist2_q  <= hist2_d;
      db_q     <= db_d;
      kpress_q <= kpress_d;
      krel_q   <= krel_d;
      swchg_q  <= swchg_d;
      ien_q    <= ien_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = 12'd0;
    if (rd_en) begin
      case (addr)
        A_SW:    rdata = {2'b00, db_q[9:0]};
        A_KEY:   rdata = {6'd0, krel_q, kpress_q, db_q[11:10]};
        A_SWCHG: rdata = {11'd0, swchg_q};
        A_IEN:   rdata = {9'd0, ien_q};
        default: rdata = 12'd0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
